// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: drives the fetch PC and the IF/ID hazard controls
// (stall, bubble, flush, fetch enable) from branch, load-use and halt
// requests. Every output comes straight from a flop.
//
// Optional performance counters are built only when the macro
// PIPE_SEQUENCER_PERF_EN is defined. Otherwise the counter ports read constant zero.
module pipe_sequencer #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned FLUSH_CYCLES = 2   // legal range 1..7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iBranchTaken,
    input  logic [ADDR_W-1:0] iBranchTarget,
    input  logic              iLoadUse,
    input  logic              iHalt,
    input  logic              iResume,
    output logic [ADDR_W-1:0] oPC,
    output logic              oFetchEn,
    output logic              oStall,
    output logic              oBubble,
    output logic              oFlush,
    output logic [15:0]       oCycleCount,
    output logic [15:0]       oStallCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t            state, state_nx;
    logic [2:0]        flush_cnt, flush_cnt_nx;
    logic [ADDR_W-1:0] pc_nx, pc_inc;
    logic              fetch_en_nx, stall_nx, bubble_nx, flush_nx;

    assign pc_inc = oPC + ADDR_W'(1);

    // State and registered outputs; reset abandons any flush or stall in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            oPC       <= '0;
            oFetchEn  <= 1'b1;
            oStall    <= 1'b0;
            oBubble   <= 1'b0;
            oFlush    <= 1'b0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
            oPC       <= pc_nx;
            oFetchEn  <= fetch_en_nx;
            oStall    <= stall_nx;
            oBubble   <= bubble_nx;
            oFlush    <= flush_nx;
        end
    end

    // Next state and next output values; priority is branch > halt > load-use.
    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        pc_nx        = oPC;
        fetch_en_nx  = oFetchEn;
        stall_nx     = oStall;
        bubble_nx    = oBubble;
        flush_nx     = oFlush;

        unique case (state)
            RUN, STALL: begin
                if (iBranchTaken) begin
                    state_nx     = FLUSH;
                    pc_nx        = iBranchTarget;
                    flush_cnt_nx = FLUSH_LAST;
                    fetch_en_nx  = 1'b1;
                    stall_nx     = 1'b0;
                    bubble_nx    = 1'b0;
                    flush_nx     = 1'b1;
                end else if (iHalt) begin
                    state_nx    = HALT;
                    fetch_en_nx = 1'b0;
                    stall_nx    = 1'b0;
                    bubble_nx   = 1'b0;
                end else if (iLoadUse) begin
                    // RUN enters STALL, STALL stays; the PC holds either way.
                    state_nx  = STALL;
                    stall_nx  = 1'b1;
                    bubble_nx = 1'b1;
                end else begin
                    state_nx  = RUN;
                    pc_nx     = pc_inc;
                    stall_nx  = 1'b0;
                    bubble_nx = 1'b0;
                end
            end
            FLUSH: begin
                // Requests are ignored here: they come from wrong-path instructions.
                pc_nx = pc_inc;
                if (flush_cnt == 3'd0) begin
                    state_nx = RUN;
                    flush_nx = 1'b0;
                end else begin
                    flush_cnt_nx = flush_cnt - 3'd1;
                    flush_nx     = 1'b1;
                end
            end
            HALT: begin
                if (iBranchTaken) begin
                    state_nx     = FLUSH;
                    pc_nx        = iBranchTarget;
                    flush_cnt_nx = FLUSH_LAST;
                    fetch_en_nx  = 1'b1;
                    flush_nx     = 1'b1;
                end else if (iResume) begin
                    state_nx    = RUN;
                    pc_nx       = pc_inc;
                    fetch_en_nx = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

`ifdef PIPE_SEQUENCER_PERF_EN
    logic [15:0] cycle_count, stall_count;

    // Saturating counters: edges since reset, and edges spent in STALL.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
            if (state == STALL && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end

    assign oCycleCount = cycle_count;
    assign oStallCount = stall_count;
`else
    assign oCycleCount = '0;
    assign oStallCount = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer. Expected output vectors
// {oPC, oFetchEn, oStall, oBubble, oFlush} are pushed to a scoreboard as
// each cycle's stimulus is driven and popped after the following edge.
module tb_pipe_sequencer;

    localparam int unsigned AW = 10;

    logic          Clock, Reset;
    logic          iBranchTaken, iLoadUse, iHalt, iResume;
    logic [AW-1:0] iBranchTarget;
    logic [AW-1:0] oPC;
    logic          oFetchEn, oStall, oBubble, oFlush;
    logic [15:0]   oCycleCount, oStallCount;

    typedef struct {
        logic          br;
        logic [AW-1:0] tgt;
        logic          lu;
        logic          h;
        logic          r;
        logic [AW+3:0] exp;
    } step_t;

    step_t         steps[$];
    logic [AW+3:0] sb[$];
    int            pass_count = 0;
    int            check_count = 0;

    pipe_sequencer #(.ADDR_W(AW), .FLUSH_CYCLES(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .iLoadUse(iLoadUse), .iHalt(iHalt), .iResume(iResume),
        .oPC(oPC), .oFetchEn(oFetchEn), .oStall(oStall), .oBubble(oBubble),
        .oFlush(oFlush), .oCycleCount(oCycleCount), .oStallCount(oStallCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW+3:0] mk(input logic [AW-1:0] pc, input logic fe, st, bu, fl);
        return {pc, fe, st, bu, fl};
    endfunction

    function automatic logic [AW+3:0] obs();
        return {oPC, oFetchEn, oStall, oBubble, oFlush};
    endfunction

    function automatic step_t idle(input logic [AW+3:0] e);
        step_t s;
        s = '{br: 1'b0, tgt: '0, lu: 1'b0, h: 1'b0, r: 1'b0, exp: e};
        return s;
    endfunction

    // Drive one cycle of stimulus, record its expectation, then move past the edge.
    task automatic drive(input step_t s);
        iBranchTaken  = s.br;
        iBranchTarget = s.tgt;
        iLoadUse      = s.lu;
        iHalt         = s.h;
        iResume       = s.r;
        sb.push_back(s.exp);
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        iBranchTaken = 0; iBranchTarget = '0; iLoadUse = 0; iHalt = 0; iResume = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // Run-up of plain idle cycles from oPC=0 to oPC=n, each one checked.
    task automatic push_idle_to(input int unsigned n);
        for (int unsigned i = 1; i <= n; i++) steps.push_back(idle(mk(AW'(i), 1, 0, 0, 0)));
    endtask

    task automatic test_reset();
        logic [AW+3:0] e;
        Reset = 1'b1;
        clear_inputs();
        #2;
        e = mk(0, 1, 0, 0, 0);
        check_count++;
        if (obs() !== e) $display("FAIL reset_async: got %h required %h", obs(), e);
        else pass_count++;
        @(posedge Clock);
        #1;
        check_count++;
        if (obs() !== e || oCycleCount !== 16'd0 || oStallCount !== 16'd0)
            $display("FAIL reset_held: got %h/%h/%h required %h/0/0", obs(), oCycleCount, oStallCount, e);
        else pass_count++;
        Reset = 1'b0;
    endtask

    task automatic test_idle();
        steps.delete();
        push_idle_to(5);
        foreach (steps[i]) begin
            logic [AW+3:0] e;
            drive(steps[i]);
            e = sb.pop_front();
            check_count++;
            if (obs() !== e) $display("FAIL idle[%0d]: got %h required %h", i, obs(), e);
            else pass_count++;
        end
    endtask

    task automatic test_branch();
        do_reset();
        steps.delete();
        push_idle_to(3);
        steps.push_back('{br: 1, tgt: 10'h200, lu: 0, h: 0, r: 0, exp: mk(10'h200, 1, 0, 0, 1)});
        // Requests during FLUSH must have no effect.
        steps.push_back('{br: 1, tgt: 10'h055, lu: 1, h: 1, r: 0, exp: mk(10'h201, 1, 0, 0, 1)});
        steps.push_back(idle(mk(10'h202, 1, 0, 0, 0)));
        steps.push_back(idle(mk(10'h203, 1, 0, 0, 0)));
        foreach (steps[i]) begin
            logic [AW+3:0] e;
            drive(steps[i]);
            e = sb.pop_front();
            check_count++;
            if (obs() !== e) $display("FAIL branch[%0d]: got %h required %h", i, obs(), e);
            else pass_count++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        steps.delete();
        push_idle_to(7);
        steps.push_back('{br: 0, tgt: '0, lu: 1, h: 0, r: 0, exp: mk(7, 1, 1, 1, 0)});
        steps.push_back('{br: 0, tgt: '0, lu: 1, h: 0, r: 0, exp: mk(7, 1, 1, 1, 0)});
        steps.push_back(idle(mk(8, 1, 0, 0, 0)));
        steps.push_back(idle(mk(9, 1, 0, 0, 0)));
        // Halt out of STALL clears the stall controls and holds the PC.
        steps.push_back('{br: 0, tgt: '0, lu: 1, h: 0, r: 0, exp: mk(9, 1, 1, 1, 0)});
        steps.push_back('{br: 0, tgt: '0, lu: 1, h: 1, r: 0, exp: mk(9, 0, 0, 0, 0)});
        steps.push_back('{br: 0, tgt: '0, lu: 0, h: 0, r: 1, exp: mk(10, 1, 0, 0, 0)});
        foreach (steps[i]) begin
            logic [AW+3:0] e;
            drive(steps[i]);
            e = sb.pop_front();
            check_count++;
            if (obs() !== e) $display("FAIL load_use[%0d]: got %h required %h", i, obs(), e);
            else pass_count++;
        end
    endtask

    task automatic test_priority();
        do_reset();
        steps.delete();
        push_idle_to(4);
        steps.push_back('{br: 1, tgt: 10'h040, lu: 1, h: 1, r: 0, exp: mk(10'h040, 1, 0, 0, 1)});
        steps.push_back(idle(mk(10'h041, 1, 0, 0, 1)));
        steps.push_back(idle(mk(10'h042, 1, 0, 0, 0)));
        // Halt beats load-use in RUN.
        steps.push_back('{br: 0, tgt: '0, lu: 1, h: 1, r: 0, exp: mk(10'h042, 0, 0, 0, 0)});
        foreach (steps[i]) begin
            logic [AW+3:0] e;
            drive(steps[i]);
            e = sb.pop_front();
            check_count++;
            if (obs() !== e) $display("FAIL priority[%0d]: got %h required %h", i, obs(), e);
            else pass_count++;
        end
    endtask

    task automatic test_halt();
        do_reset();
        steps.delete();
        push_idle_to(12);
        steps.push_back('{br: 0, tgt: '0, lu: 0, h: 1, r: 0, exp: mk(12, 0, 0, 0, 0)});
        for (int unsigned i = 0; i < 9; i++)
            steps.push_back('{br: 0, tgt: '0, lu: i[0], h: i[1], r: 0, exp: mk(12, 0, 0, 0, 0)});
        steps.push_back('{br: 0, tgt: '0, lu: 0, h: 1, r: 1, exp: mk(13, 1, 0, 0, 0)});
        steps.push_back(idle(mk(14, 1, 0, 0, 0)));
        // Branch out of HALT, with the flushed PC wrapping past the top.
        steps.push_back('{br: 0, tgt: '0, lu: 0, h: 1, r: 0, exp: mk(14, 0, 0, 0, 0)});
        steps.push_back('{br: 1, tgt: 10'h3FF, lu: 0, h: 0, r: 0, exp: mk(10'h3FF, 1, 0, 0, 1)});
        steps.push_back(idle(mk(10'h000, 1, 0, 0, 1)));
        steps.push_back(idle(mk(10'h001, 1, 0, 0, 0)));
        foreach (steps[i]) begin
            logic [AW+3:0] e;
            drive(steps[i]);
            e = sb.pop_front();
            check_count++;
            if (obs() !== e) $display("FAIL halt[%0d]: got %h required %h", i, obs(), e);
            else pass_count++;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [AW+3:0] e;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            do_reset();
            steps.delete();
            push_idle_to(2);
            if (pass == 0)
                steps.push_back('{br: 1, tgt: 10'h100, lu: 0, h: 0, r: 0, exp: mk(10'h100, 1, 0, 0, 1)});
            else
                steps.push_back('{br: 0, tgt: '0, lu: 1, h: 0, r: 0, exp: mk(2, 1, 1, 1, 0)});
            foreach (steps[i]) begin
                drive(steps[i]);
                e = sb.pop_front();
                check_count++;
                if (obs() !== e) $display("FAIL mid_op%0d_setup[%0d]: got %h required %h", pass, i, obs(), e);
                else pass_count++;
            end
            // Assert reset between edges: outputs must clear without a clock.
            clear_inputs();
            Reset = 1'b1;
            #1;
            e = mk(0, 1, 0, 0, 0);
            check_count++;
            if (obs() !== e || oCycleCount !== 16'd0 || oStallCount !== 16'd0)
                $display("FAIL mid_op%0d_async: got %h/%h/%h required %h/0/0",
                         pass, obs(), oCycleCount, oStallCount, e);
            else pass_count++;
            @(posedge Clock);
            #1;
            Reset = 1'b0;
            steps.delete();
            push_idle_to(2);
            foreach (steps[i]) begin
                drive(steps[i]);
                e = sb.pop_front();
                check_count++;
                if (obs() !== e) $display("FAIL mid_op%0d_after[%0d]: got %h required %h", pass, i, obs(), e);
                else pass_count++;
            end
        end
    endtask

    task automatic test_perf();
        step_t s;
        do_reset();
        for (int unsigned i = 0; i < 3; i++) drive(idle(mk(AW'(i + 1), 1, 0, 0, 0)));
        s = '{br: 0, tgt: '0, lu: 1, h: 0, r: 0, exp: mk(3, 1, 1, 1, 0)};
        drive(s);
        drive(s);
        drive(idle(mk(4, 1, 0, 0, 0)));
        sb.delete();
`ifdef PIPE_SEQUENCER_PERF_EN
        check_count++;
        if (oCycleCount !== 16'd6 || oStallCount !== 16'd2)
            $display("FAIL perf_counts: got cycle=%0d stall=%0d required cycle=6 stall=2", oCycleCount, oStallCount);
        else pass_count++;
        clear_inputs();
        repeat (65540) @(posedge Clock);
        #1;
        check_count++;
        if (oCycleCount !== 16'hFFFF)
            $display("FAIL perf_saturate: got %h required ffff", oCycleCount);
        else pass_count++;
        do_reset();
        check_count++;
        if (oCycleCount !== 16'd0 || oStallCount !== 16'd0)
            $display("FAIL perf_reset: got cycle=%0d stall=%0d required 0/0", oCycleCount, oStallCount);
        else pass_count++;
`else
        check_count++;
        if (oCycleCount !== 16'd0 || oStallCount !== 16'd0)
            $display("FAIL perf_disabled: got cycle=%0d stall=%0d required 0/0", oCycleCount, oStallCount);
        else pass_count++;
`endif
    endtask

    initial begin
        test_reset();
        test_idle();
        test_branch();
        test_load_use();
        test_priority();
        test_halt();
        test_reset_mid_op();
        test_perf();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, PC and branch-target width in bits.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles oFlush stays high after a taken branch; legal range 1..7.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port iBranchTaken  input  1  branch resolved taken this cycle.
REQ-006 SHALL have port iBranchTarget  input  ADDR_W  branch destination address.
REQ-007 SHALL have port iLoadUse  input  1  load-use hazard detected between ID and EX.
REQ-008 SHALL have port iHalt  input  1  halt request from the decoder.
REQ-009 SHALL have port iResume  input  1  leave HALT.
REQ-010 SHALL have port oPC  output  ADDR_W  registered fetch address to instruction memory.
REQ-011 SHALL have port oFetchEn  output  1  instruction fetch valid; low in HALT.
REQ-012 SHALL have port oStall  output  1  hold the IF/ID pipeline register.
REQ-013 SHALL have port oBubble  output  1  inject NOP (all enables low) into EX.
REQ-014 SHALL have port oFlush  output  1  clear IF/ID contents (wrong-path kill).
REQ-015 SHALL have ports oCycleCount and oStallCount  output  16 each  performance counters (see Configuration).

Function
REQ-016 SHALL implement states RUN, STALL, FLUSH, HALT; all outputs SHALL be registered.
REQ-017 SHALL apply per-cycle priority: iBranchTaken > iHalt > iLoadUse > normal advance.
REQ-018 SHALL, in RUN with no request, set oPC <= oPC+1 modulo 2^ADDR_W (e.g. 1023 -> 0 for ADDR_W=10).
REQ-019 SHALL, on iBranchTaken=1 in RUN, STALL or HALT, set oPC <= iBranchTarget, oFlush <= 1, flush counter <= FLUSH_CYCLES-1, and enter FLUSH.
REQ-020 SHALL, in FLUSH, increment oPC each cycle, keep oFlush=1, and decrement the counter; on the edge where the counter is 0 it SHALL enter RUN with oFlush <= 0.
REQ-021 SHALL ignore iBranchTaken, iHalt and iLoadUse while in FLUSH; flushed instructions cannot raise them validly.
REQ-022 SHALL, on iLoadUse=1 in RUN, hold oPC, set oStall <= 1 and oBubble <= 1, and enter STALL.
REQ-023 SHALL remain in STALL, holding oPC, while iLoadUse=1; when iLoadUse=0 it SHALL return to RUN, clear oStall/oBubble and resume incrementing.
REQ-024 SHALL, on iHalt=1 in RUN or STALL, hold oPC, set oFetchEn <= 0, clear oStall/oBubble, and enter HALT.
REQ-025 SHALL leave HALT only on iResume=1 (to RUN, oFetchEn <= 1, oPC <= oPC+1) or on iBranchTaken=1 (per REQ-019).
REQ-026 SHALL treat iHalt and iResume both high in HALT as iResume.

Reset
REQ-027 SHALL, while Reset=1, force state RUN, oPC=0, oFetchEn=1, oStall=0, oBubble=0, oFlush=0, flush counter=0, and both performance counters=0, independent of Clock.
REQ-028 SHALL, when Reset asserts mid-FLUSH or mid-STALL, abandon the operation fully; the first edge after release SHALL behave as RUN from oPC=0.

Configuration
REQ-029 SHALL, with macro PIPE_SEQUENCER_PERF_EN defined, increment oCycleCount on every non-reset edge and oStallCount on every edge leaving state STALL or HALT-as-stall (state STALL only), both saturating at 16'hFFFF.
REQ-030 SHALL, without PIPE_SEQUENCER_PERF_EN, keep the ports but drive oCycleCount and oStallCount constant 0, with no counter flops.

Verification
REQ-031 SHALL cover: reset release, 5 idle cycles -> oPC 0,1,2,3,4,5, oFetchEn=1, all others 0.
REQ-032 SHALL cover: iBranchTaken=1 with target 10'h200 at oPC=3 -> oPC=200h, then 201h, 202h; oFlush high exactly 2 cycles; RUN after.
REQ-033 SHALL cover: iLoadUse high 2 cycles at oPC=7 -> oPC holds 7 for 2 cycles, oStall=oBubble=1 for 2 cycles, then 8.
REQ-034 SHALL cover: iBranchTaken and iLoadUse and iHalt together at oPC=4, target 40h -> branch wins, FLUSH entered, no stall, no halt.
REQ-035 SHALL cover: iHalt at oPC=12 -> oFetchEn=0, oPC holds 12 for 10 cycles; iResume -> oPC=13, oFetchEn=1.
REQ-036 SHALL cover: Reset pulse mid-FLUSH at counter=1 -> outputs reset immediately; with PIPE_SEQUENCER_PERF_EN, counters read 0, and oCycleCount saturates at FFFFh after 65535+ cycles.
